// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: DEPTH x BITS register file with READ_PORTS combinational
// read ports, one synchronous write port, x0 hardwired to zero, and a
// per-register busy scoreboard (issue sets, writeback clears, flush clears all).
// Optional build macro REGFILE_BYPASS_EN adds a same-cycle write-to-read bypass.
module regfile_scoreboard #(
   parameter int DEPTH      = 32,
   parameter int BITS       = 64,
   parameter int READ_PORTS = 2,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
   output logic [READ_PORTS*BITS-1:0]   rd_data,
   output logic [READ_PORTS-1:0]        rd_busy,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [BITS-1:0]              wr_data,
   input  logic                         issue_en,
   input  logic [ADDR_W-1:0]            issue_addr,
   input  logic                         flush,
   output logic [DEPTH-1:0]             busy_vec,
   output logic [ADDR_W:0]              busy_cnt
);

   localparam int CNT_W = ADDR_W + 1;

   logic [DEPTH-1:0][BITS-1:0] regs;
   logic [DEPTH-1:0]           busy;
   logic [CNT_W-1:0]           cnt;

   logic                       wr_ok;
   logic                       set_hit;
   logic                       clr_hit;
   logic                       inc;
   logic                       dec;
   logic [DEPTH-1:0]           busy_nxt;
   logic [CNT_W-1:0]           cnt_nxt;

   assign wr_ok = wr_en && (wr_addr != '0);

   // Data storage: x0 is never written, so it stays at its reset value of 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         regs <= '0;
      else if (wr_ok)
         regs[wr_addr] <= wr_data;
   end

   // Next scoreboard state: flush > issue > writeback. An issue to the same
   // register as a writeback keeps it busy since the new producer supersedes.
   always_comb begin
      set_hit  = !flush && issue_en && (issue_addr != '0);
      clr_hit  = !flush && wr_ok && !(set_hit && (issue_addr == wr_addr));
      inc      = set_hit && !busy[issue_addr];
      dec      = clr_hit && busy[wr_addr];
      busy_nxt = busy;
      if (flush) begin
         busy_nxt = '0;
      end else begin
         if (clr_hit) busy_nxt[wr_addr]    = 1'b0;
         if (set_hit) busy_nxt[issue_addr] = 1'b1;
      end
      // set and clear never target the same register here, so the count can
      // be tracked from the two transitions independently.
      cnt_nxt = flush ? '0 : (cnt + CNT_W'(inc) - CNT_W'(dec));
   end

   // Scoreboard registers; the count is kept incrementally to avoid a popcount.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
         cnt  <= '0;
      end else begin
         busy <= busy_nxt;
         cnt  <= cnt_nxt;
      end
   end

   assign busy_vec = busy;
   assign busy_cnt = cnt;

   // Independent read ports; address 0 reads as zero and never busy.
   for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zero;
      assign a    = rd_addr[p*ADDR_W +: ADDR_W];
      assign zero = (a == '0);
`ifdef REGFILE_BYPASS_EN
      logic hit;
      assign hit = wr_ok && (wr_addr == a);
      assign rd_data[p*BITS +: BITS] = zero ? '0 : (hit ? wr_data : regs[a]);
      assign rd_busy[p] = flush ? 1'b0 :
                          zero  ? 1'b0 :
                          hit   ? (issue_en && (issue_addr == a)) : busy[a];
`else
      assign rd_data[p*BITS +: BITS] = zero ? '0 : regs[a];
      assign rd_busy[p] = !zero && busy[a];
`endif
   end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core register file: DEPTH x BITS storage, READ_PORTS combinational read ports, one synchronous write port, and x0 hardwired to zero.
- Adds an asynchronous active-low reset that clears all storage.
- Adds a per-register busy scoreboard: issue marks a destination pending, writeback clears it, flush clears all.
- Sits between decode/issue (consumes rd_busy to stall) and writeback (drives wr_*).

Parameters:
- DEPTH, 32, number of architectural registers (power of 2, >=2); ADDR_W = $clog2(DEPTH) derived localparam
- BITS, 64, register data width
- READ_PORTS, 2, number of independent read ports (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- rd_addr  input  READ_PORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- rd_data  output  READ_PORTS*BITS  packed read data; port p at [p*BITS +: BITS]
- rd_busy  output  READ_PORTS  1 = addressed register has a pending producer
- wr_en  input  1  writeback strobe
- wr_addr  input  ADDR_W  writeback destination
- wr_data  input  BITS  writeback value
- issue_en  input  1  mark issue_addr busy
- issue_addr  input  ADDR_W  destination being issued
- flush  input  1  clear every busy bit
- busy_vec  output  DEPTH  current busy bits; bit 0 is always 0
- busy_cnt  output  ADDR_W+1  number of busy registers

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, busy_vec = 0, busy_cnt = 0. Outputs follow in the same delta; no clock needed.
- Reads: combinational, zero latency. Address 0 always returns 0 with rd_busy = 0. All ports are independent; identical addresses on several ports are legal.
- Write: on posedge with wr_en, reg[wr_addr] <= wr_data. wr_addr = 0 is ignored with no side effects.
- Scoreboard update per posedge, in priority order:
  - flush: busy_vec <= 0, busy_cnt <= 0. Any simultaneous issue is dropped. A simultaneous write still updates data.
  - else issue_en with issue_addr != 0: busy[issue_addr] <= 1. This wins over a same-cycle writeback to the same address, because the new producer supersedes the old one.
  - else wr_en with wr_addr != 0: busy[wr_addr] <= 0.
  - Issue and writeback to different addresses in one cycle: both take effect.
- busy_cnt: maintained incrementally (+1 on a 0->1 transition, -1 on 1->0, net 0 when both happen in one cycle). It must always equal popcount(busy_vec).
- Re-issue of an already-busy register: the bit stays 1 and the count does not change.
- Writeback to a non-busy register: data is written and the count does not change.
- Range: busy_cnt saturates naturally at DEPTH-1, since x0 is never busy; no overflow is possible.
- Reset asserted mid-cycle overrides everything. Deassertion is synchronised externally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a same-cycle write-to-read bypass. When wr_en is set, wr_addr != 0 and rd_addr[p] == wr_addr:
  - rd_data[p] = wr_data.
  - rd_busy[p] = 0, unless issue_en targets the same address in that cycle (then 1).
  - flush asserted forces rd_busy[p] = 0 for all ports.
- Undefined: reads return the stored value and the registered busy bit; the written data is visible from the next cycle.

Test Plan:
- Reset: assert rst_n=0 between edges -> rd_data all 0, busy_vec=0, busy_cnt=0 immediately. Write 0xDEAD to r5, then reset -> r5 reads 0.
- x0: wr_en, wr_addr=0, wr_data=0xFFFF_FFFF_FFFF_FFFF; issue_addr=0 -> reads of r0 return 0, rd_busy=0, busy_cnt=0.
- Scoreboard: issue r3, r7 on successive cycles -> busy_cnt=2, busy_vec[3]=busy_vec[7]=1. Write r3=0x1234 -> busy_cnt=1, r3 reads 0x1234. Flush -> busy_cnt=0.
- Collision: issue_addr=4 and wr_addr=4 in the same cycle with r4 busy -> r4 still busy, busy_cnt unchanged, r4 data = wr_data. Flush plus issue r9 -> busy_vec=0.
- Multi-port: READ_PORTS=4, addresses 1,2,1,31 after writes 0xA, 0xB, 0xC (to r31) -> rd_data = 0xA, 0xB, 0xA, 0xC.
- Bypass: write r6=0x55 while reading r6 -> with REGFILE_BYPASS_EN 0x55 in the same cycle; without it, the old value, then 0x55 next cycle.
